// File: rtl/usb_packet_rx.sv
// USB full/low-speed packet receiver: oversampled bit recovery, NRZI decode, unstuffing,
// SYNC/PID/payload/CRC16 capture, EOP detection and a held result with overflow tracking.
module usb_packet_rx #(
   parameter int unsigned SAMPLES_PER_BIT = 30,
   parameter int unsigned MAX_BYTES       = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       USBdata,
   output logic [7:0]                       PID_data,
   output logic [8*MAX_BYTES-1:0]           data,
   output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count,
   output logic [15:0]                      CRC_data,
   output logic                             EOP_found,
   output logic                             pkt_valid,
   input  logic                             pkt_ack,
   output logic [4:0]                       err_flags
);

   localparam int unsigned CW  = $clog2(SAMPLES_PER_BIT);
   localparam int unsigned BCW = $clog2(MAX_BYTES + 1);
   localparam int unsigned TW  = $clog2(MAX_BYTES + 3);
   localparam int unsigned DW  = 8 * MAX_BYTES;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;
   localparam logic [1:0] LINE_SE1 = 2'b11;

   localparam int unsigned E_OVF = 4;
   localparam int unsigned E_ALN = 3;
   localparam int unsigned E_LEN = 2;
   localparam int unsigned E_CRC = 1;
   localparam int unsigned E_PID = 0;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_HOLD
   } state_e;

   // Serial CRC16 step, bits fed in line order
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   state_e            state_q, state_d;
   logic [1:0]        line_q;
   logic [CW-1:0]     cnt_q;
   logic              prev_j_q, prev_j_d;
   logic [2:0]        sync_cnt_q, sync_cnt_d;
   logic [2:0]        run_q, run_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        pid_q, pid_d;
   logic [TW-1:0]     tot_q, tot_d;
   logic [7:0]        dly0_q, dly0_d;
   logic [7:0]        dly1_q, dly1_d;
   logic [DW-1:0]     buf_q, buf_d;
   logic [15:0]       crc_q, crc_d;
   logic              aln_q, aln_d;
   logic              len_q, len_d;
   logic [1:0]        se0_cnt_q, se0_cnt_d;
   logic              discard_q, discard_d;

   logic [7:0]        pid_o_q, pid_o_d;
   logic [DW-1:0]     data_o_q, data_o_d;
   logic [BCW-1:0]    cnt_o_q, cnt_o_d;
   logic [15:0]       crc_o_q, crc_o_d;
   logic [4:0]        err_o_q, err_o_d;
   logic              eop_q, eop_d;
   logic              valid_q, valid_d;

   logic [CW-1:0]     cnt_c;
   logic              stb_c, is_j_c, is_k_c, is_se0_c, is_se1_c, is_jk_c, dbit_c;
   logic              ack_c, sync_det_c, start_c;
   logic [DW-1:0]     lat_data_c;
   logic [BCW-1:0]    lat_cnt_c;
   logic [15:0]       lat_crc_c;
   logic [4:0]        lat_err_c;

   // Bit-time counter realigns on every line change; one sample per bit at mid-bit
   assign cnt_c    = (USBdata != line_q) ? '0 :
                     (cnt_q == CW'(SAMPLES_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
   assign stb_c    = (cnt_c == CW'(SAMPLES_PER_BIT / 2));
   assign is_j_c   = (USBdata == LINE_J);
   assign is_k_c   = (USBdata == LINE_K);
   assign is_se0_c = (USBdata == LINE_SE0);
   assign is_se1_c = (USBdata == LINE_SE1);
   assign is_jk_c  = is_j_c | is_k_c;
   assign dbit_c   = (is_j_c == prev_j_q);

   assign ack_c      = valid_q & pkt_ack;
   assign sync_det_c = stb_c && (state_q == S_HOLD) && is_jk_c && dbit_c && (sync_cnt_q == 3'd7);
   assign start_c    = stb_c && (((state_q == S_IDLE) && is_k_c) || (sync_det_c && ack_c));

   // Result image captured when an EOP completes
   always_comb begin
      lat_data_c = buf_q;
      lat_cnt_c  = '0;
      lat_crc_c  = '0;
      lat_err_c  = '0;
      lat_err_c[E_PID] = (pid_q[7:4] != ~pid_q[3:0]);
      lat_err_c[E_ALN] = aln_q || (bit_cnt_q != 3'd0);
      lat_err_c[E_LEN] = len_q;
      if (pid_q[1:0] == 2'b11) begin
         if (tot_q < TW'(2)) begin
            lat_err_c[E_LEN] = 1'b1;
         end else begin
            lat_cnt_c        = BCW'(tot_q - TW'(2));
            lat_crc_c        = {dly0_q, dly1_q};
            lat_err_c[E_CRC] = (crc_q != 16'h800D);
         end
      end else begin
         if (tot_q > TW'(MAX_BYTES)) begin
            lat_err_c[E_LEN] = 1'b1;
            lat_cnt_c        = BCW'(MAX_BYTES);
         end else begin
            lat_cnt_c = BCW'(tot_q);
         end
         // Bytes still in the delay buffer belong to the payload for non-data PIDs
         for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (int'(tot_q) == i + 1) begin
               lat_data_c[8*i +: 8] = dly0_q;
            end else if (int'(tot_q) == i + 2) begin
               lat_data_c[8*i +: 8] = dly1_q;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      prev_j_d   = prev_j_q;
      sync_cnt_d = sync_cnt_q;
      run_d      = run_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pid_d      = pid_q;
      tot_d      = tot_q;
      dly0_d     = dly0_q;
      dly1_d     = dly1_q;
      buf_d      = buf_q;
      crc_d      = crc_q;
      aln_d      = aln_q;
      len_d      = len_q;
      se0_cnt_d  = se0_cnt_q;
      discard_d  = discard_q;
      pid_o_d    = pid_o_q;
      data_o_d   = data_o_q;
      cnt_o_d    = cnt_o_q;
      crc_o_d    = crc_o_q;
      err_o_d    = err_o_q;
      eop_d      = 1'b0;
      valid_d    = valid_q;

      if (ack_c) begin
         valid_d = 1'b0;
      end

      if (start_c) begin
         bit_cnt_d = '0;
         shift_d   = '0;
         pid_d     = '0;
         tot_d     = '0;
         dly0_d    = '0;
         dly1_d    = '0;
         buf_d     = '0;
         crc_d     = 16'hFFFF;
         aln_d     = 1'b0;
         len_d     = 1'b0;
         se0_cnt_d = '0;
         run_d     = '0;
         discard_d = 1'b0;
      end

      if (state_q == S_HOLD && ack_c && !sync_det_c) begin
         state_d = S_IDLE;
      end

      if (stb_c) begin
         if (is_jk_c) begin
            prev_j_d = is_j_c;
         end else if (is_se0_c) begin
            prev_j_d = 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (is_k_c) begin
                  state_d    = S_SYNC;
                  sync_cnt_d = 3'd1;
               end
            end
            S_SYNC: begin
               if (is_se1_c) begin
                  aln_d   = 1'b1;
                  state_d = S_EOP;
               end else if (!is_jk_c) begin
                  state_d = S_IDLE;
               end else if (!dbit_c && sync_cnt_q != 3'd7) begin
                  sync_cnt_d = sync_cnt_q + 3'd1;
               end else if (dbit_c && sync_cnt_q == 3'd7) begin
                  state_d = S_PID;
                  run_d   = 3'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PID, S_DATA: begin
               if (is_se0_c) begin
                  state_d   = S_EOP;
                  se0_cnt_d = 2'd1;
               end else if (is_se1_c) begin
                  aln_d   = 1'b1;
                  state_d = S_EOP;
               end else if (run_q == 3'd6) begin
                  // Stuffed position: a 0 is dropped, a 1 is a framing violation
                  run_d = '0;
                  if (dbit_c) begin
                     aln_d   = 1'b1;
                     state_d = S_EOP;
                  end
               end else begin
                  run_d     = dbit_c ? run_q + 3'd1 : 3'd0;
                  shift_d   = {dbit_c, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (state_q == S_DATA) begin
                     crc_d = crc16_step(crc_q, dbit_c);
                  end
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == S_PID) begin
                        pid_d   = shift_d;
                        state_d = S_DATA;
                     end else if (tot_q == TW'(MAX_BYTES + 2)) begin
                        len_d = 1'b1;
                     end else begin
                        tot_d  = tot_q + TW'(1);
                        dly1_d = dly0_q;
                        dly0_d = shift_d;
                        for (int i = 0; i < int'(MAX_BYTES); i++) begin
                           if (int'(tot_q) == i + 2) begin
                              buf_d[8*i +: 8] = dly1_q;
                           end
                        end
                     end
                  end
               end
            end
            S_EOP: begin
               if (is_se0_c) begin
                  if (se0_cnt_q != 2'd2) begin
                     se0_cnt_d = se0_cnt_q + 2'd1;
                  end
               end else if (is_j_c && se0_cnt_q == 2'd2) begin
                  eop_d      = 1'b1;
                  se0_cnt_d  = '0;
                  sync_cnt_d = '0;
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = valid_d ? S_HOLD : S_IDLE;
                  end else begin
                     pid_o_d  = pid_q;
                     data_o_d = lat_data_c;
                     cnt_o_d  = lat_cnt_c;
                     crc_o_d  = lat_crc_c;
                     err_o_d  = lat_err_c;
                     valid_d  = 1'b1;
                     state_d  = S_HOLD;
                  end
               end else begin
                  se0_cnt_d = '0;
               end
            end
            S_HOLD: begin
               // Watch for a new SYNC while the previous result is still unread
               if (!is_jk_c) begin
                  sync_cnt_d = '0;
               end else if (!dbit_c) begin
                  sync_cnt_d = (sync_cnt_q == 3'd7) ? 3'd0 : sync_cnt_q + 3'd1;
               end else if (sync_cnt_q == 3'd7) begin
                  sync_cnt_d = '0;
                  if (ack_c) begin
                     state_d = S_PID;
                     run_d   = 3'd1;
                  end else begin
                     err_o_d[E_OVF] = 1'b1;
                     discard_d      = 1'b1;
                     se0_cnt_d      = '0;
                     state_d        = S_EOP;
                  end
               end else begin
                  sync_cnt_d = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         line_q     <= LINE_J;
         cnt_q      <= '0;
         prev_j_q   <= 1'b1;
         sync_cnt_q <= '0;
         run_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         pid_q      <= '0;
         tot_q      <= '0;
         dly0_q     <= '0;
         dly1_q     <= '0;
         buf_q      <= '0;
         crc_q      <= 16'hFFFF;
         aln_q      <= 1'b0;
         len_q      <= 1'b0;
         se0_cnt_q  <= '0;
         discard_q  <= 1'b0;
         pid_o_q    <= '0;
         data_o_q   <= '0;
         cnt_o_q    <= '0;
         crc_o_q    <= '0;
         err_o_q    <= '0;
         eop_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= USBdata;
         cnt_q      <= cnt_c;
         prev_j_q   <= prev_j_d;
         sync_cnt_q <= sync_cnt_d;
         run_q      <= run_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         pid_q      <= pid_d;
         tot_q      <= tot_d;
         dly0_q     <= dly0_d;
         dly1_q     <= dly1_d;
         buf_q      <= buf_d;
         crc_q      <= crc_d;
         aln_q      <= aln_d;
         len_q      <= len_d;
         se0_cnt_q  <= se0_cnt_d;
         discard_q  <= discard_d;
         pid_o_q    <= pid_o_d;
         data_o_q   <= data_o_d;
         cnt_o_q    <= cnt_o_d;
         crc_o_q    <= crc_o_d;
         err_o_q    <= err_o_d;
         eop_q      <= eop_d;
         valid_q    <= valid_d;
      end
   end

   assign PID_data   = pid_o_q;
   assign data       = data_o_q;
   assign byte_count = cnt_o_q;
   assign CRC_data   = crc_o_q;
   assign err_flags  = err_o_q;
   assign EOP_found  = eop_q;
   assign pkt_valid  = valid_q;

endmodule

// File: tb/tb_usb_packet_rx.sv
// Directed bench for usb_packet_rx: NRZI/bit-stuffing line encoder and hand-computed results.
module tb_usb_packet_rx;

   localparam int unsigned SPB = 8;
   localparam int unsigned MB  = 4;
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [1:0]                  usb;
   logic [7:0]                  pid_data;
   logic [8*MB-1:0]             data;
   logic [$clog2(MB+1)-1:0]     byte_count;
   logic [15:0]                 crc_data;
   logic                        eop_found;
   logic                        pkt_valid;
   logic                        pkt_ack;
   logic [4:0]                  err_flags;

   int n_vec = 0;
   int n_bad = 0;
   int eop_cnt = 0;
   int e0;
   logic lvl_j;
   int ones;
   logic bad_stuff;

   usb_packet_rx #(.SAMPLES_PER_BIT(SPB), .MAX_BYTES(MB)) dut (
      .clk(clk), .rst(rst), .USBdata(usb), .PID_data(pid_data), .data(data),
      .byte_count(byte_count), .CRC_data(crc_data), .EOP_found(eop_found),
      .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (eop_found === 1'b1) eop_cnt++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic line(input logic [1:0] v);
      usb = v;
      repeat (SPB) @(negedge clk);
   endtask

   task automatic raw_bit(input logic b);
      if (!b) lvl_j = ~lvl_j;
      line(lvl_j ? J : K);
   endtask

   task automatic tx_bit(input logic b);
      raw_bit(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
         raw_bit(bad_stuff);
         ones = 0;
      end
   endtask

   task automatic tx_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) tx_bit(b[i]);
   endtask

   task automatic tx_sync();
      lvl_j = 1'b1;
      ones  = 0;
      tx_byte(8'h80);
   endtask

   task automatic tx_eop();
      line(SE0);
      line(SE0);
      line(J);
      lvl_j = 1'b1;
      ones  = 0;
      line(J);
      line(J);
   endtask

   // bytes[7:0] goes first on the wire; extra zero bits model a truncated byte
   task automatic send_pkt(input logic [63:0] bytes, input int n, input int extra);
      tx_sync();
      for (int i = 0; i < n; i++) tx_byte(bytes[8*i +: 8]);
      for (int i = 0; i < extra; i++) tx_bit(1'b0);
      tx_eop();
   endtask

   task automatic do_ack(input string tag);
      @(negedge clk) pkt_ack = 1'b1;
      @(negedge clk) pkt_ack = 1'b0;
      chk(tag, 64'(pkt_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1; usb = J; pkt_ack = 1'b0; bad_stuff = 1'b0; lvl_j = 1'b1; ones = 0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(pkt_valid), 64'd0);
      chk("rst_pid",   64'(pid_data),  64'd0);
      chk("rst_err",   64'(err_flags), 64'd0);
      chk("rst_data",  64'(data),      64'd0);
      chk("rst_eop",   64'(eop_found), 64'd0);
      rst = 1'b0;
      repeat (2 * SPB) @(negedge clk);

      // ACK handshake
      e0 = eop_cnt;
      send_pkt(64'hD2, 1, 0);
      chk("ack_pid",   64'(pid_data),   64'hD2);
      chk("ack_cnt",   64'(byte_count), 64'd0);
      chk("ack_err",   64'(err_flags),  64'd0);
      chk("ack_valid", 64'(pkt_valid),  64'd1);
      chk("ack_eop1",  64'(eop_cnt - e0), 64'd1);
      chk("ack_data",  64'(data),       64'd0);
      do_ack("ack_release");

      // Zero-length DATA0, good CRC
      send_pkt(64'h00_00_C3, 3, 0);
      chk("d0_pid",   64'(pid_data),   64'hC3);
      chk("d0_cnt",   64'(byte_count), 64'd0);
      chk("d0_crc",   64'(crc_data),   64'h0000);
      chk("d0_err",   64'(err_flags),  64'd0);
      do_ack("d0_release");

      // Zero-length DATA0, corrupted CRC
      send_pkt(64'h01_00_C3, 3, 0);
      chk("d0bad_err", 64'(err_flags), 64'h02);
      chk("d0bad_crc", 64'(crc_data),  64'h0100);
      do_ack("d0bad_release");

      // OUT token with a stuffed bit inside 0xFF
      send_pkt(64'h00_FF_E1, 3, 0);
      chk("out_pid",  64'(pid_data),   64'hE1);
      chk("out_data", 64'(data),       64'h0000_00FF);
      chk("out_cnt",  64'(byte_count), 64'd2);
      chk("out_err",  64'(err_flags),  64'd0);
      chk("out_crc",  64'(crc_data),   64'd0);
      do_ack("out_release");

      // Same token, stuffed bit sent as 1
      bad_stuff = 1'b1;
      send_pkt(64'h00_FF_E1, 3, 0);
      bad_stuff = 1'b0;
      chk("stuff_err", 64'(err_flags), 64'h08);
      do_ack("stuff_release");

      // PID check nibble wrong
      send_pkt(64'hD1, 1, 0);
      chk("pid_pid", 64'(pid_data),  64'hD1);
      chk("pid_err", 64'(err_flags), 64'h01);
      do_ack("pid_release");

      // Partial byte before EOP
      send_pkt(64'hD2, 1, 3);
      chk("part_err", 64'(err_flags),  64'h08);
      chk("part_cnt", 64'(byte_count), 64'd0);
      do_ack("part_release");

      // Seven bytes after PID on a token: beyond MAX_BYTES+2
      send_pkt(64'h77665544332211E1, 8, 0);
      chk("long_data", 64'(data),       64'h4433_2211);
      chk("long_cnt",  64'(byte_count), 64'd4);
      chk("long_err",  64'(err_flags),  64'h04);
      do_ack("long_release");

      // Second packet while the first is unacknowledged
      send_pkt(64'hD2, 1, 0);
      chk("ovf_first_valid", 64'(pkt_valid), 64'd1);
      send_pkt(64'h01_00_C3, 3, 0);
      chk("ovf_valid", 64'(pkt_valid),  64'd1);
      chk("ovf_pid",   64'(pid_data),   64'hD2);
      chk("ovf_err",   64'(err_flags),  64'h10);
      chk("ovf_cnt",   64'(byte_count), 64'd0);
      chk("ovf_crc",   64'(crc_data),   64'd0);
      do_ack("ovf_release");

      // Reset in the middle of the third data byte
      tx_sync();
      tx_byte(8'hC3);
      tx_byte(8'h11);
      tx_byte(8'h22);
      for (int i = 0; i < 4; i++) tx_bit(1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_pid",   64'(pid_data),  64'd0);
      chk("mid_rst_err",   64'(err_flags), 64'd0);
      chk("mid_rst_valid", 64'(pkt_valid), 64'd0);
      chk("mid_rst_data",  64'(data),      64'd0);
      repeat (3) @(negedge clk);
      usb = J; lvl_j = 1'b1; ones = 0;
      rst = 1'b0;
      repeat (3) line(J);
      e0 = eop_cnt;
      send_pkt(64'hD2, 1, 0);
      chk("post_rst_pid",   64'(pid_data),  64'hD2);
      chk("post_rst_err",   64'(err_flags), 64'd0);
      chk("post_rst_valid", 64'(pkt_valid), 64'd1);
      chk("post_rst_eop1",  64'(eop_cnt - e0), 64'd1);
      do_ack("post_rst_release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/usb_packet_rx.md
USB_PACKET_RX -- requirements
Module: usb_packet_rx

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 30, is the number of clk cycles per USB bit time (minimum 4).
REQ-002 Parameter MAX_BYTES, default 8, is the maximum payload bytes per packet, excluding PID and CRC.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port USBdata, input, 2: line state; [1]=D+, [0]=D-; J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
REQ-006 Port PID_data, output, 8: received PID byte.
REQ-007 Port data, output, 8*MAX_BYTES: payload; byte n occupies bits [8n+7:8n], and unused bytes are 0.
REQ-008 Port byte_count, output, $clog2(MAX_BYTES+1): number of valid payload bytes.
REQ-009 Port CRC_data, output, 16: received CRC16 field, first-received byte in [7:0].
REQ-010 Port EOP_found, output, 1: one-cycle pulse when an EOP completes.
REQ-011 Port pkt_valid, output, 1: packet outputs are stable and valid.
REQ-012 Port pkt_ack, input, 1: consumer acknowledge.
REQ-013 Port err_flags, output, 5: {overflow, align, length, crc, pid}.

Function
REQ-014 Bit recovery: a cycle counter restarts on every J/K transition; the line is sampled once per bit when the counter equals SAMPLES_PER_BIT/2, and the counter wraps at SAMPLES_PER_BIT.
REQ-015 NRZI decoding: a sample equal to the previous sampled J/K level gives 1; a differing sample gives 0. The previous level is J at idle.
REQ-016 States: IDLE, SYNC, PID, DATA, EOP, HOLD.
REQ-017 IDLE: enter SYNC on the first sampled K.
REQ-018 SYNC: the decoded pattern 0000_0001 (KJKJKJKK) moves to PID; any mismatch or SE0 returns to IDLE with no error flag.
REQ-019 Bits are assembled LSB first; each completed byte is shifted into a 2-byte delay buffer before it is committed to data.
REQ-020 Bit unstuffing: after six consecutive decoded 1s the next bit is discarded and the run counter is cleared. If that discarded bit is 1, set align and go to EOP-wait.
REQ-021 PID check: PID[7:4] != ~PID[3:0] sets the pid flag.
REQ-022 EOP detection: two consecutive SE0 samples followed by a J sample. EOP_found pulses the cycle after the J sample.
REQ-023 Length rules:
- An EOP with a partial byte pending (1-7 bits) sets align.
- More than MAX_BYTES+2 bytes after the PID sets length, and further bytes are discarded.
REQ-024 Data PIDs (PID[1:0]==2'b11):
- The last two bytes received are CRC_data.
- byte_count = total bytes - 2.
- Fewer than 2 bytes sets length.
- The CRC16 register (polynomial 0x8005, init 0xFFFF, reflected) runs over payload and CRC bits; a final residual other than 16'h800D sets crc.
REQ-025 Other PIDs: all bytes after the PID go to data, CRC_data=0, and no CRC check is made.
REQ-026 SE1 sampled in SYNC, PID or DATA sets align and waits for EOP.
REQ-027 On EOP, outputs and err_flags are latched and pkt_valid rises in the same cycle as EOP_found; the state becomes HOLD.
REQ-028 HOLD: pkt_valid stays high until a cycle with pkt_ack=1; the next cycle pkt_valid=0 and the state is IDLE. The receiver keeps tracking the line.
REQ-029 A SYNC detected while in HOLD sets overflow on the held packet. That packet is discarded up to its EOP, and the held outputs are unchanged.
REQ-030 pkt_ack while pkt_valid=0 is ignored.

Reset
REQ-031 rst=1 immediately forces: state IDLE; PID_data, data, byte_count, CRC_data, err_flags = 0; EOP_found, pkt_valid = 0; previous level J; counters 0.
REQ-032 rst asserted mid-packet aborts the packet. After release the block waits in IDLE for a fresh SYNC.

Verification
REQ-033 ACK: SYNC, PID 0xD2, EOP -> PID_data=8'hD2, byte_count=0, err_flags=0, pkt_valid=1, EOP_found pulses once.
REQ-034 Zero-length DATA0: C3 00 00, EOP -> PID_data=8'hC3, byte_count=0, CRC_data=16'h0000, err_flags=0.
REQ-035 Same packet as C3 00 01 -> crc flag set (err_flags=5'b00010), CRC_data=16'h0100.
REQ-036 OUT token E1 FF 00 with a stuffed bit after the six 1s -> data[15:0]=16'h00FF, byte_count=2, no align error. The same packet with the stuffed bit sent as 1 -> align flag set.
REQ-037 pkt_ack held low and a second packet sent -> overflow set, first packet's outputs unchanged. Pulse pkt_ack -> pkt_valid=0 the next cycle.
REQ-038 Assert rst during DATA byte 3 -> all outputs 0 immediately. After release, a following clean ACK packet is received correctly.
